// File: rtl/lw_sha_axi4_dma_master.sv
`timescale 1ns/1ps
// AXI4 master feeding the SHA accelerator: fixed-address write bursts of message words, then an optional incrementing digest read.
// Latency: AW/AR valid one cycle after the pacing request is seen; W and R beats pass through combinationally.
// Backpressure: s_ready mirrors wready inside a write burst, rready mirrors m_ready during the digest read.
module lw_sha_axi4_dma_master #(
   parameter int          DATA_WIDTH = 32,
   parameter logic [11:0] DIN_ADDR   = 12'h020,
   parameter logic [11:0] HASH_ADDR  = 12'h040,
   parameter int          MAX_BURST  = 16,
   parameter int          HASH_WORDS = 8
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [15:0]           cmd_len,
   input  logic                  cmd_rd_hash,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   output logic                  m_last,
   input  logic                  m_ready,
   input  logic                  dma_wr_req_i,
   input  logic                  dma_rd_req_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [11:0]           awaddr,
   output logic [7:0]            awlen,
   output logic [2:0]            awsize,
   output logic [1:0]            awburst,
   output logic [3:0]            awid,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  wlast,
   output logic                  wvalid,
   input  logic                  wready,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready,
   output logic [11:0]           araddr,
   output logic [7:0]            arlen,
   output logic [2:0]            arsize,
   output logic [1:0]            arburst,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            rresp,
   input  logic                  rlast,
   input  logic                  rvalid,
   output logic                  rready
);

   typedef struct packed {
      logic [11:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ax_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_ADDR,
      S_WR_DATA,
      S_WR_RESP,
      S_RD_REQ,
      S_RD_ADDR,
      S_RD_DATA,
      S_DONE
   } state_t;

   localparam logic [2:0]  AXSIZE      = 3'($clog2(DATA_WIDTH / 8));
   localparam logic [15:0] MAX_BURST_W = 16'(MAX_BURST);
   localparam logic [7:0]  HASH_LEN    = 8'(HASH_WORDS - 1);
   localparam logic [1:0]  BURST_FIXED = 2'b00;
   localparam logic [1:0]  BURST_INCR  = 2'b01;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] remaining;
   logic        rd_hash;
   logic [8:0]  blen;
   logic [8:0]  blen_nxt;
   logic [8:0]  beat_cnt;
   ax_t         aw_q;
   ax_t         ar_q;
   logic        awvalid_q;
   logic        arvalid_q;
   logic        err_q;
   logic        done_q;
   logic        rst_done;

   // Last burst of a command is short when fewer than MAX_BURST words remain.
   assign blen_nxt = (remaining > MAX_BURST_W) ? 9'(MAX_BURST) : remaining[8:0];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      s_ready   = 1'b0;
      wvalid    = 1'b0;
      wlast     = 1'b0;
      bready    = 1'b0;
      m_valid   = 1'b0;
      m_last    = 1'b0;
      rready    = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = rst_done;
            if (cmd_valid && rst_done) begin
               if (cmd_len != 16'd0) begin
                  state_nxt = S_WR_REQ;
               end else if (cmd_rd_hash) begin
                  state_nxt = S_RD_REQ;
               end else begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_WR_REQ: begin
            if (dma_wr_req_i) begin
               state_nxt = S_WR_ADDR;
            end
         end
         S_WR_ADDR: begin
            if (awready) begin
               state_nxt = S_WR_DATA;
            end
         end
         S_WR_DATA: begin
            wvalid  = s_valid;
            s_ready = wready;
            wlast   = (beat_cnt == (blen - 9'd1));
            if (s_valid && wready && wlast) begin
               state_nxt = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            bready = 1'b1;
            if (bvalid) begin
               if (bresp != 2'b00) begin
                  state_nxt = S_DONE;
               end else if (remaining != {7'd0, blen}) begin
                  state_nxt = S_WR_REQ;
               end else if (rd_hash) begin
                  state_nxt = S_RD_REQ;
               end else begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_RD_REQ: begin
            if (dma_rd_req_i) begin
               state_nxt = S_RD_ADDR;
            end
         end
         S_RD_ADDR: begin
            if (arready) begin
               state_nxt = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            m_valid = rvalid;
            m_last  = rlast;
            rready  = m_ready;
            if (rvalid && m_ready && rlast) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         remaining <= 16'd0;
         rd_hash   <= 1'b0;
         blen      <= 9'd0;
         beat_cnt  <= 9'd0;
         aw_q      <= '0;
         ar_q      <= '0;
         awvalid_q <= 1'b0;
         arvalid_q <= 1'b0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         rst_done  <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         done_q   <= (state == S_DONE);
         case (state)
            S_IDLE: begin
               if (cmd_valid && rst_done) begin
                  remaining <= cmd_len;
                  rd_hash   <= cmd_rd_hash;
                  err_q     <= 1'b0;
               end
            end
            S_WR_REQ: begin
               if (dma_wr_req_i) begin
                  blen      <= blen_nxt;
                  beat_cnt  <= 9'd0;
                  awvalid_q <= 1'b1;
                  aw_q      <= '{addr: DIN_ADDR, len: 8'(blen_nxt - 9'd1),
                                 size: AXSIZE, burst: BURST_FIXED};
               end
            end
            S_WR_ADDR: begin
               if (awready) begin
                  awvalid_q <= 1'b0;
               end
            end
            S_WR_DATA: begin
               if (s_valid && wready) begin
                  beat_cnt <= beat_cnt + 9'd1;
               end
            end
            S_WR_RESP: begin
               if (bvalid) begin
                  if (bresp != 2'b00) begin
                     err_q <= 1'b1;
                  end else begin
                     remaining <= remaining - {7'd0, blen};
                  end
               end
            end
            S_RD_REQ: begin
               if (dma_rd_req_i) begin
                  arvalid_q <= 1'b1;
                  ar_q      <= '{addr: HASH_ADDR, len: HASH_LEN,
                                 size: AXSIZE, burst: BURST_INCR};
               end
            end
            S_RD_ADDR: begin
               if (arready) begin
                  arvalid_q <= 1'b0;
               end
            end
            S_RD_DATA: begin
               // A bad beat is flagged but the burst is drained to keep the slave in step.
               if (rvalid && m_ready && (rresp != 2'b00)) begin
                  err_q <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign awvalid = awvalid_q;
   assign awaddr  = aw_q.addr;
   assign awlen   = aw_q.len;
   assign awsize  = aw_q.size;
   assign awburst = aw_q.burst;
   assign awid    = 4'd0;

   assign arvalid = arvalid_q;
   assign araddr  = ar_q.addr;
   assign arlen   = ar_q.len;
   assign arsize  = ar_q.size;
   assign arburst = ar_q.burst;

   assign wdata  = s_data;
   assign m_data = rdata;

   assign busy_o = (state != S_IDLE);
   assign done_o = done_q;
   assign err_o  = err_q;

endmodule

// File: tb/tb_lw_sha_axi4_dma_master.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus queues expected AW/W/AR/digest beats, a negedge monitor pops and compares.
module tb_lw_sha_axi4_dma_master;
   localparam int DW = 32;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          cmd_valid, cmd_ready, cmd_rd_hash;
   logic [15:0]   cmd_len;
   logic [DW-1:0] s_data, m_data, wdata, rdata;
   logic          s_valid, s_ready, m_valid, m_last, m_ready;
   logic          dma_wr_req_i, dma_rd_req_i, busy_o, done_o, err_o;
   logic [11:0]   awaddr, araddr;
   logic [7:0]    awlen, arlen;
   logic [2:0]    awsize, arsize;
   logic [1:0]    awburst, arburst, bresp, rresp;
   logic [3:0]    awid;
   logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rlast, rvalid, rready;

   always #5 aclk = ~aclk;

   lw_sha_axi4_dma_master dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_rd_hash(cmd_rd_hash),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .dma_wr_req_i(dma_wr_req_i), .dma_rd_req_i(dma_rd_req_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   typedef struct packed {
      logic [11:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ax_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   ax_t           exp_aw[$];
   ax_t           exp_ar[$];
   beat_t         exp_w[$];
   beat_t         exp_m[$];
   logic [DW-1:0] src_q[$];
   logic [1:0]    bresp_q[$];
   logic [31:0]   digest [8];

   int          checks = 0;
   int          failures = 0;
   int          w_beats = 0;
   logic [31:0] word_seq = 32'hC0DE_0001;
   bit          rnd_gap = 0, rnd_m = 0, pace = 0;
   logic [1:0]  rresp_val = 2'b00;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   ax_t   mon_ax;
   beat_t mon_b;
   logic  awvalid_prev = 1'b0, wr_req_prev = 1'b0;

   always @(negedge aclk) begin
      if (aresetn) begin
         if (awvalid && !awvalid_prev) check("aw_only_after_wr_req", 64'(wr_req_prev), 64'd1);
         if (awvalid && awready) begin
            check("aw_expected", 64'(exp_aw.size() > 0), 64'd1);
            if (exp_aw.size() > 0) begin
               mon_ax = exp_aw.pop_front();
               check("aw_fields", 64'({awaddr, awlen, awsize, awburst}), 64'(mon_ax));
            end
            check("awid", 64'(awid), 64'd0);
         end
         if (wvalid && wready) begin
            w_beats++;
            check("w_expected", 64'(exp_w.size() > 0), 64'd1);
            if (exp_w.size() > 0) begin
               mon_b = exp_w.pop_front();
               check("w_beat", 64'({wdata, wlast}), 64'(mon_b));
            end
         end
         if (arvalid && arready) begin
            check("ar_expected", 64'(exp_ar.size() > 0), 64'd1);
            if (exp_ar.size() > 0) begin
               mon_ax = exp_ar.pop_front();
               check("ar_fields", 64'({araddr, arlen, arsize, arburst}), 64'(mon_ax));
            end
         end
         if (rvalid) check("rready_follows_m_ready", 64'(rready), 64'(m_ready));
         if (m_valid && m_ready) begin
            check("m_expected", 64'(exp_m.size() > 0), 64'd1);
            if (exp_m.size() > 0) begin
               mon_b = exp_m.pop_front();
               check("m_beat", 64'({m_data, m_last}), 64'(mon_b));
            end
         end
      end
      awvalid_prev = awvalid;
      wr_req_prev  = dma_wr_req_i;
   end

   // ---------------- slave / stream source ----------------
   int       pend_b = 0, pace_cnt = 0;
   logic [3:0] r_idx = 4'd0, r_cnt = 4'd0;
   bit       s_fire, wl_fire, b_fire, ar_fire, r_fire;

   always begin
      @(negedge aclk);
      s_fire  = s_valid && s_ready;
      wl_fire = wvalid && wready && wlast;
      b_fire  = bvalid && bready;
      ar_fire = arvalid && arready;
      r_fire  = rvalid && rready;
      @(posedge aclk);
      #1;
      if (!aresetn) begin
         src_q.delete();
         bresp_q.delete();
         pend_b = 0; pace_cnt = 0;
         r_idx = 4'd0; r_cnt = 4'd0;
         s_valid = 1'b0; bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
         dma_wr_req_i = 1'b1;
      end else begin
         if (s_fire) void'(src_q.pop_front());
         if (!(s_valid && !s_fire)) begin
            if (src_q.size() > 0 && (!rnd_gap || $urandom_range(0, 3) != 0)) begin
               s_valid = 1'b1;
               s_data  = src_q[0];
            end else begin
               s_valid = 1'b0;
            end
         end
         wready = rnd_gap ? 1'($urandom_range(0, 1)) : 1'b1;
         if (b_fire) bvalid = 1'b0;
         if (wl_fire) pend_b++;
         if (!bvalid && pend_b > 0) begin
            bvalid = 1'b1;
            bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
            pend_b--;
         end
         if (pace && b_fire) pace_cnt = 10;
         if (pace_cnt > 0) begin
            dma_wr_req_i = 1'b0;
            pace_cnt--;
         end else begin
            dma_wr_req_i = 1'b1;
         end
         if (ar_fire) begin
            r_cnt = 4'd8;
            r_idx = 4'd0;
         end
         if (r_fire) r_idx = r_idx + 4'd1;
         if (r_idx < r_cnt) begin
            rvalid = 1'b1;
            rdata  = digest[r_idx[2:0]];
            rlast  = (r_idx == r_cnt - 4'd1);
            rresp  = rresp_val;
         end else begin
            rvalid = 1'b0;
            rlast  = 1'b0;
         end
         m_ready = rnd_m ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_burst(input int blen, input logic [1:0] resp);
      exp_aw.push_back('{addr: 12'h020, len: 8'(blen - 1), size: 3'd2, burst: 2'b00});
      bresp_q.push_back(resp);
      for (int i = 0; i < blen; i++) begin
         src_q.push_back(word_seq);
         exp_w.push_back('{data: word_seq, last: (i == blen - 1)});
         word_seq = word_seq + 32'h0101_0101;
      end
   endtask

   task automatic push_digest();
      exp_ar.push_back('{addr: 12'h040, len: 8'd7, size: 3'd2, burst: 2'b01});
      for (int i = 0; i < 8; i++) exp_m.push_back('{data: digest[3'(i)], last: (i == 7)});
   endtask

   task automatic send_cmd(input logic [15:0] len, input logic rd);
      bit ok = 0;
      @(posedge aclk);
      #1;
      cmd_len = len; cmd_rd_hash = rd; cmd_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge aclk);
         ok = cmd_ready;
         @(posedge aclk);
         #1;
      end
      cmd_valid = 1'b0;
      check("cmd_accept", 64'(ok), 64'd1);
   endtask

   task automatic wait_done(input string name, input logic exp_err, input int budget, output int lat);
      bit seen = 0;
      int n = 0;
      while (!seen && n < budget) begin
         @(negedge aclk);
         n++;
         if (done_o) seen = 1;
      end
      lat = n;
      check({name, "_done"}, 64'(seen), 64'd1);
      check({name, "_err"}, 64'(err_o), 64'(exp_err));
      check({name, "_idle"}, 64'(busy_o), 64'd0);
      check({name, "_aw_left"}, 64'(exp_aw.size()), 64'd0);
      check({name, "_w_left"}, 64'(exp_w.size()), 64'd0);
      check({name, "_ar_left"}, 64'(exp_ar.size()), 64'd0);
      check({name, "_m_left"}, 64'(exp_m.size()), 64'd0);
   endtask

   task automatic check_quiet(input string name);
      check({name, "_awvalid"}, 64'(awvalid), 64'd0);
      check({name, "_wvalid"}, 64'(wvalid), 64'd0);
      check({name, "_s_ready"}, 64'(s_ready), 64'd0);
      check({name, "_bready"}, 64'(bready), 64'd0);
      check({name, "_arvalid"}, 64'(arvalid), 64'd0);
      check({name, "_rready"}, 64'(rready), 64'd0);
      check({name, "_m_valid"}, 64'(m_valid), 64'd0);
      check({name, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
      check({name, "_busy"}, 64'(busy_o), 64'd0);
      check({name, "_done"}, 64'(done_o), 64'd0);
      check({name, "_err"}, 64'(err_o), 64'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int lat, base, n;
      digest = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
      cmd_valid = 1'b0; cmd_len = 16'd0; cmd_rd_hash = 1'b0;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      dma_wr_req_i = 1'b1; dma_rd_req_i = 1'b1;
      awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b1; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;

      repeat (3) @(negedge aclk);
      check_quiet("reset");
      check("reset_awaddr", 64'({awaddr, awlen}), 64'd0);
      check("reset_araddr", 64'({araddr, arlen}), 64'd0);
      @(posedge aclk);
      #1 aresetn = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

      // single short burst
      push_burst(5, 2'b00);
      send_cmd(16'd5, 1'b0);
      wait_done("len5", 1'b0, 200, lat);

      // 40 words with pacing gaps between bursts
      pace = 1;
      push_burst(16, 2'b00); push_burst(16, 2'b00); push_burst(8, 2'b00);
      send_cmd(16'd40, 1'b0);
      wait_done("len40", 1'b0, 600, lat);
      pace = 0;
      repeat (12) @(negedge aclk);

      // write then digest read with m_ready stalls
      rnd_m = 1;
      push_burst(16, 2'b00);
      push_digest();
      send_cmd(16'd16, 1'b1);
      wait_done("len16_hash", 1'b0, 400, lat);
      rnd_m = 0;

      // slave error on first burst: nothing further issued
      push_burst(16, 2'b10);
      send_cmd(16'd32, 1'b1);
      wait_done("bresp_err", 1'b1, 300, lat);
      repeat (5) @(negedge aclk);
      check("bresp_err_no_more_w", 64'(src_q.size()), 64'd0);

      // random stream and wready gaps
      rnd_gap = 1;
      push_burst(16, 2'b00); push_burst(16, 2'b00); push_burst(5, 2'b00);
      send_cmd(16'd37, 1'b0);
      wait_done("gaps", 1'b0, 1500, lat);
      rnd_gap = 0;

      // empty command without digest
      send_cmd(16'd0, 1'b0);
      wait_done("len0", 1'b0, 20, lat);
      check("len0_done_latency", 64'(lat), 64'd2);

      // digest read with rresp error still drains all beats
      rresp_val = 2'b10;
      push_burst(1, 2'b00);
      push_digest();
      send_cmd(16'd1, 1'b1);
      wait_done("rresp_err", 1'b1, 200, lat);
      rresp_val = 2'b00;

      // reset in the middle of a write burst
      rnd_gap = 1;
      push_burst(16, 2'b00); push_burst(4, 2'b00);
      send_cmd(16'd20, 1'b0);
      base = w_beats; n = 0;
      while (w_beats < base + 3 && n < 300) begin
         @(negedge aclk);
         n++;
      end
      check("mid_burst_reached", 64'(w_beats >= base + 3), 64'd1);
      #2 aresetn = 1'b0;
      #1;
      check_quiet("async_reset");
      exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_m.delete();
      src_q.delete(); bresp_q.delete();
      rnd_gap = 0;
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      check("cmd_ready_after_rerelease", 64'(cmd_ready), 64'd1);
      push_burst(1, 2'b00);
      send_cmd(16'd1, 1'b0);
      wait_done("after_reset", 1'b0, 200, lat);

      repeat (3) @(negedge aclk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
